// File: rtl/onchip_arb_pkg.sv
// rtl/onchip_arb_pkg.sv - shared constants and types for the on-chip RAM arbiter
package onchip_arb_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int MEM_DEPTH = 40000;

    typedef logic master_idx_t;

    localparam logic [DATA_W-1:0] OOR_READDATA = 32'h0;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant; last_grant state lives in the parent
module rr_arb2
    import onchip_arb_pkg::*;
(
    input  logic [1:0]  req_i,
    input  logic        hold_i,
    input  master_idx_t last_grant_i,
    output logic [1:0]  grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (!hold_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                // On contention the master that did not win last time goes first.
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// rtl/onchip_memory_arbiter.sv - two-master round-robin arbiter for the single-port on-chip RAM
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W    = onchip_arb_pkg::ADDR_W,
    parameter int DATA_W    = onchip_arb_pkg::DATA_W,
    parameter int BE_W      = onchip_arb_pkg::BE_W,
    parameter int MEM_DEPTH = onchip_arb_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              range_err
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    master_idx_t       sel;
    logic [ADDR_W-1:0] addr_sel;
    logic              wr_sel;
    logic              in_range;
    logic [DATA_W-1:0] rd_data;

    master_idx_t last_grant_q, last_grant_d;
    logic        rd_pend_q, rd_pend_d;
    master_idx_t rd_owner_q, rd_owner_d;
    logic        rd_oor_q, rd_oor_d;
    logic        range_err_q, range_err_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    // Reset is folded into hold so no grant (and no RAM access) can occur while reset is low.
    rr_arb2 u_arb (
        .req_i        (req),
        .hold_i       (hold | ~reset_n),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign accept   = |(req & grant);
    assign sel      = grant[1];
    assign addr_sel = sel ? m1_address : m0_address;
    assign wr_sel   = sel ? m1_write   : m0_write;
    assign in_range = 32'(addr_sel) < MEM_DEPTH;

    assign m0_waitrequest = ~reset_n | (req[0] & ~grant[0]);
    assign m1_waitrequest = ~reset_n | (req[1] & ~grant[1]);

    assign mem_address    = addr_sel;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
    assign mem_chipselect = accept & in_range;
    assign mem_write      = accept & in_range & wr_sel;
    assign mem_clken      = reset_n;

    always_comb begin
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_oor_d     = rd_oor_q;
        rd_pend_d    = accept & ~wr_sel;
        range_err_d  = range_err_q | (accept & ~in_range);
        if (accept) begin
            last_grant_d = sel;
        end
        if (rd_pend_d) begin
            rd_owner_d = sel;
            rd_oor_d   = ~in_range;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
            range_err_q  <= range_err_d;
        end
    end

    // Out-of-range reads never touched the RAM, so their return slot carries a fixed value.
    assign rd_data = rd_oor_q ? DATA_W'(OOR_READDATA) : mem_readdata;

    assign m0_readdatavalid = rd_pend_q & (rd_owner_q == 1'b0);
    assign m1_readdatavalid = rd_pend_q & (rd_owner_q == 1'b1);
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;
    assign range_err        = range_err_q;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb/tb_onchip_memory_arbiter.sv - directed scoreboard bench for onchip_memory_arbiter
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        hold;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        range_err;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram[int];
    logic [31:0] shadow[int];
    logic [31:0] ram_next;
    logic        ram_rd_pend;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          w;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .hold             (hold),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .range_err        (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [15:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : {16'hC0DE, a};
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [15:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : {16'hC0DE, a};
    endfunction

    // Called at the falling edge: checks returns, records accepted accesses, models the RAM.
    task automatic mon();
        logic        v0, v1, rd, wr;
        logic [15:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        exp_t        e;
        v0 = m0_readdatavalid;
        v1 = m1_readdatavalid;
        if (v0 | v1) begin
            chk("rv_one_owner", 32'(v0 & v1), 0);
            if (sb.size() == 0) begin
                chk("rv_unexpected", 32'(v0 | v1), 0);
            end else begin
                e = sb.pop_front();
                chk("rv_owner", 32'(v1), 32'(e.owner));
                chk("rv_data", v1 ? m1_readdata : m0_readdata, e.data);
                chk("rv_nonowner", v1 ? m0_readdata : m1_readdata, 0);
            end
        end else if (sb.size() != 0) begin
            chk("rv_missing", 32'(v0 | v1), 1);
            sb.delete();
        end
        if (reset_n) begin
            for (int m = 0; m < 2; m++) begin
                rd = (m == 1) ? m1_read : m0_read;
                wr = (m == 1) ? m1_write : m0_write;
                a  = (m == 1) ? m1_address : m0_address;
                wd = (m == 1) ? m1_writedata : m0_writedata;
                be = (m == 1) ? m1_byteenable : m0_byteenable;
                if ((rd | wr) && !((m == 1) ? m1_waitrequest : m0_waitrequest)) begin
                    if (rd) begin
                        e.owner = (m == 1);
                        e.data  = (int'(a) < 40000) ? shadow_rd(a) : 32'h0;
                        sb.push_back(e);
                    end else if (int'(a) < 40000) begin
                        shadow[int'(a)] = merge(shadow_rd(a), wd, be);
                    end
                end
            end
        end
        ram_rd_pend = 1'b0;
        if (mem_chipselect) begin
            if (mem_write) begin
                ram[int'(mem_address)] = merge(ram_rd(mem_address), mem_writedata, mem_byteenable);
            end else begin
                ram_next    = ram_rd(mem_address);
                ram_rd_pend = 1'b1;
            end
        end
    endtask

    task automatic step();
        mon();
        @(posedge clk);
        if (ram_rd_pend) mem_readdata = ram_next;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {m0_read, m0_write, m1_read, m1_write, hold} = '0;
        m0_address = '0; m1_address = '0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;
        mem_readdata = '0;
        ram_next = '0; ram_rd_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait0", 32'(m0_waitrequest), 1);
        chk("rst_wait1", 32'(m1_waitrequest), 1);
        chk("rst_cs", 32'(mem_chipselect), 0);
        reset_n = 1'b1;

        // 1: idle after reset
        @(negedge clk);
        chk("t1_rdv0", 32'(m0_readdatavalid), 0);
        chk("t1_rdv1", 32'(m1_readdatavalid), 0);
        chk("t1_cs", 32'(mem_chipselect), 0);
        chk("t1_range_err", 32'(range_err), 0);
        chk("t1_clken", 32'(mem_clken), 1);
        step();

        // 2: m0 write then read, no wait states
        m0_write = 1'b1; m0_address = 16'h0010; m0_writedata = 32'hA5A5_0001; m0_byteenable = 4'hF;
        @(negedge clk);
        chk("t2_wr_wait", 32'(m0_waitrequest), 0);
        chk("t2_wr_cs", 32'(mem_chipselect), 1);
        chk("t2_wr_we", 32'(mem_write), 1);
        chk("t2_wr_addr", 32'(mem_address), 32'h0010);
        step();
        m0_write = 1'b0; m0_read = 1'b1;
        @(negedge clk);
        chk("t2_rd_wait", 32'(m0_waitrequest), 0);
        chk("t2_rd_we", 32'(mem_write), 0);
        step();
        m0_read = 1'b0;
        @(negedge clk);
        chk("t2_rdv", 32'(m0_readdatavalid), 1);
        chk("t2_data", m0_readdata, 32'hA5A5_0001);
        step();

        // 3: continuous contention; m0 won last, so m1 goes first
        m0_read = 1'b1; m0_address = 16'h0100;
        m1_read = 1'b1; m1_address = 16'h0200;
        for (int i = 0; i < 6; i++) begin
            w = (i % 2 == 0) ? 1 : 0;
            @(negedge clk);
            chk("t3_wait0", 32'(m0_waitrequest), 32'(w));
            chk("t3_wait1", 32'(m1_waitrequest), 32'(1 - w));
            chk("t3_addr", 32'(mem_address), (w == 1) ? 32'h0200 : 32'h0100);
            chk("t3_cs", 32'(mem_chipselect), 1);
            step();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        idle(1);

        // 4: partial write merge, then read-before-write ordering
        m1_write = 1'b1; m1_address = 16'h0300; m1_writedata = 32'hFFFF_FFFF; m1_byteenable = 4'hF;
        idle(1);
        m1_writedata = 32'h0000_1234; m1_byteenable = 4'b0011;
        idle(1);
        m1_write = 1'b0;
        m0_read = 1'b1; m0_address = 16'h0300;
        idle(1);
        m0_read = 1'b0;
        m1_write = 1'b1; m1_writedata = 32'hDEAD_0000; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("t4_rdv", 32'(m0_readdatavalid), 1);
        chk("t4_merged_old", m0_readdata, 32'hFFFF_1234);
        step();
        m1_write = 1'b0;
        m0_read = 1'b1;
        idle(1);
        m0_read = 1'b0;
        @(negedge clk);
        chk("t4_new", m0_readdata, 32'hDEAD_0000);
        step();

        // 5: out-of-range read is trapped and returns zero
        m0_read = 1'b1; m0_address = 16'h9C40;
        @(negedge clk);
        chk("t5_wait", 32'(m0_waitrequest), 0);
        chk("t5_cs", 32'(mem_chipselect), 0);
        step();
        m0_read = 1'b0;
        @(negedge clk);
        chk("t5_rdv", 32'(m0_readdatavalid), 1);
        chk("t5_data", m0_readdata, 32'h0);
        chk("t5_range_err", 32'(range_err), 1);
        step();
        m0_read = 1'b1; m0_address = 16'h0010;
        idle(1);
        m0_read = 1'b0;
        idle(2);
        chk("t5_sticky", 32'(range_err), 1);

        // 6: hold blocks grants; reset drops a pending read
        hold = 1'b1;
        m0_read = 1'b1; m0_address = 16'h0400;
        m1_read = 1'b1; m1_address = 16'h0500;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_wait0", 32'(m0_waitrequest), 1);
            chk("t6_wait1", 32'(m1_waitrequest), 1);
            chk("t6_cs", 32'(mem_chipselect), 0);
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("t6_rel_wait1", 32'(m1_waitrequest), 0);
        step();
        m1_read = 1'b0;
        idle(1);
        m0_read = 1'b0;
        idle(1);
        m0_read = 1'b1; m0_address = 16'h0010;
        @(negedge clk);
        chk("t6_pre_wait", 32'(m0_waitrequest), 0);
        step();
        reset_n = 1'b0;
        m0_read = 1'b0;
        #1;
        chk("t6_rst_rdv0", 32'(m0_readdatavalid), 0);
        chk("t6_rst_wait0", 32'(m0_waitrequest), 1);
        chk("t6_rst_range_err", 32'(range_err), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_post_rdv0", 32'(m0_readdatavalid), 0);
        chk("t6_post_rdv1", 32'(m1_readdatavalid), 0);
        step();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
